// File: rtl/gray2bin_tracker_if.sv
// ---------------------------------------------------------------------------
// gray2bin_tracker_if
//   Bundles the sample stream and the tracker results of gray2bin_tracker.
//
//   Signals (master = sample source / result consumer, slave = tracker):
//     clr        master->slave  synchronous soft clear of tracking state
//     gin        master->slave  Gray-coded sample, WIDTH bits
//     gin_valid  master->slave  gin is qualified this cycle
//     bin_out    slave->master  registered binary of last accepted sample
//     bin_valid  slave->master  one-cycle pulse when bin_out updates
//     step_up    slave->master  one-cycle pulse for a +1 step
//     step_dn    slave->master  one-cycle pulse for a -1 step
//     step_err   slave->master  one-cycle pulse for an illegal jump
//     position   slave->master  signed up/down accumulator, POS_W bits
//     err_cnt    slave->master  saturating count of illegal jumps
// ---------------------------------------------------------------------------
interface gray2bin_tracker_if #(
  parameter int WIDTH = 3,
  parameter int POS_W = 16
);
  logic             clr;
  logic [WIDTH-1:0] gin;
  logic             gin_valid;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_up;
  logic             step_dn;
  logic             step_err;
  logic [POS_W-1:0] position;
  logic [7:0]       err_cnt;

  modport master (
    output clr, gin, gin_valid,
    input  bin_out, bin_valid, step_up, step_dn, step_err, position, err_cnt
  );

  modport slave (
    input  clr, gin, gin_valid,
    output bin_out, bin_valid, step_up, step_dn, step_err, position, err_cnt
  );
endinterface

// File: rtl/gray2bin_tracker.sv
// ---------------------------------------------------------------------------
// gray2bin_tracker
//   Converts a Gray-coded position sample into binary and tracks the motion
//   between consecutive accepted samples: +1 / -1 steps move a signed
//   accumulator, any larger jump is flagged and counted.
//
//   Parameters:
//     WIDTH  Gray / binary width (>= 2)
//     POS_W  width of the position accumulator
//
//   Ports:
//     clk   sole clock, rising edge
//     rst   synchronous active-high reset, highest priority
//     bus   gray2bin_tracker_if.slave (clr, gin, gin_valid in; results out)
//
//   Configuration macro:
//     G2B_INSYNC_EN  when defined, gin and gin_valid each pass through a
//                    two-flop synchroniser before conversion (latency 3
//                    cycles instead of 1). The synchroniser clears on rst
//                    and on clr.
// ---------------------------------------------------------------------------
module gray2bin_tracker #(
  parameter int WIDTH = 3,
  parameter int POS_W = 16
) (
  input logic             clk,
  input logic             rst,
  gray2bin_tracker_if.slave bus
);

  typedef enum logic {INIT = 1'b0, TRACK = 1'b1} state_t;

  // Sample presented to the conversion stage.
  logic [WIDTH-1:0] conv_gin;
  logic             conv_valid;

`ifdef G2B_INSYNC_EN
  logic [WIDTH-1:0] gin_s1_reg;
  logic [WIDTH-1:0] gin_s2_reg;
  logic             valid_s1_reg;
  logic             valid_s2_reg;

  // Both stages clear on clr so a sample in flight cannot reach the
  // tracker after a soft clear.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      gin_s1_reg   <= '0;
      gin_s2_reg   <= '0;
      valid_s1_reg <= 1'b0;
      valid_s2_reg <= 1'b0;
    end else begin
      gin_s1_reg   <= bus.gin;
      gin_s2_reg   <= gin_s1_reg;
      valid_s1_reg <= bus.gin_valid;
      valid_s2_reg <= valid_s1_reg;
    end
  end

  assign conv_gin   = gin_s2_reg;
  assign conv_valid = valid_s2_reg;
`else
  assign conv_gin   = bus.gin;
  assign conv_valid = bus.gin_valid;
`endif

  // Gray to binary: each binary bit is the XOR of all Gray bits at or
  // above it, which unrolls b[i] = b[i+1] ^ g[i] without a combinational
  // chain through the same vector.
  logic [WIDTH-1:0] bin_conv;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_conv
      assign bin_conv[gi] = ^conv_gin[WIDTH-1:gi];
    end
  endgenerate

  // bin_out_reg doubles as the previous-sample register: both are loaded
  // with the new value on every accepted sample and both clear together.
  state_t           state_reg,    state_next;
  logic [WIDTH-1:0] bin_out_reg,  bin_out_next;
  logic             bin_valid_reg, bin_valid_next;
  logic             step_up_reg,  step_up_next;
  logic             step_dn_reg,  step_dn_next;
  logic             step_err_reg, step_err_next;
  logic [POS_W-1:0] position_reg, position_next;
  logic [7:0]       err_cnt_reg,  err_cnt_next;

  // Modular difference; wrap across 2^WIDTH-1 <-> 0 falls out naturally.
  logic [WIDTH-1:0] delta;
  assign delta = bin_conv - bin_out_reg;

  always_comb begin
    state_next     = state_reg;
    bin_out_next   = bin_out_reg;
    bin_valid_next = 1'b0;
    step_up_next   = 1'b0;
    step_dn_next   = 1'b0;
    step_err_next  = 1'b0;
    position_next  = position_reg;
    err_cnt_next   = err_cnt_reg;

    if (conv_valid) begin
      bin_out_next   = bin_conv;
      bin_valid_next = 1'b1;
      unique case (state_reg)
        INIT: begin
          // First sample only establishes the reference point.
          state_next = TRACK;
        end
        TRACK: begin
          if (delta == WIDTH'(0)) begin
            // No motion.
          end else if (delta == WIDTH'(1)) begin
            step_up_next  = 1'b1;
            position_next = position_reg + POS_W'(1);
          end else if (delta == {WIDTH{1'b1}}) begin
            step_dn_next  = 1'b1;
            position_next = position_reg - POS_W'(1);
          end else begin
            step_err_next = 1'b1;
            if (err_cnt_reg != 8'hFF) begin
              err_cnt_next = err_cnt_reg + 8'd1;
            end
          end
        end
        default: state_next = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state_reg     <= INIT;
      bin_out_reg   <= '0;
      bin_valid_reg <= 1'b0;
      step_up_reg   <= 1'b0;
      step_dn_reg   <= 1'b0;
      step_err_reg  <= 1'b0;
      position_reg  <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      bin_out_reg   <= bin_out_next;
      bin_valid_reg <= bin_valid_next;
      step_up_reg   <= step_up_next;
      step_dn_reg   <= step_dn_next;
      step_err_reg  <= step_err_next;
      position_reg  <= position_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign bus.bin_out   = bin_out_reg;
  assign bus.bin_valid = bin_valid_reg;
  assign bus.step_up   = step_up_reg;
  assign bus.step_dn   = step_dn_reg;
  assign bus.step_err  = step_err_reg;
  assign bus.position  = position_reg;
  assign bus.err_cnt   = err_cnt_reg;

  // Step classification is mutually exclusive by construction.
  step_onehot_a : assert property (@(posedge clk) disable iff (rst)
    $onehot0({step_up_reg, step_dn_reg, step_err_reg}));

endmodule

// File: tb/tb_gray2bin_tracker.sv
// ---------------------------------------------------------------------------
// tb_gray2bin_tracker
//   Self-checking bench for gray2bin_tracker (WIDTH=3, POS_W=16). Directed
//   scenarios followed by randomized traffic; every cycle's outputs are
//   compared against a behavioural model of the tracking rules.
// ---------------------------------------------------------------------------
module tb_gray2bin_tracker;
  localparam int WIDTH = 3;
  localparam int POS_W = 16;
  localparam int MOD   = 1 << WIDTH;
`ifdef G2B_INSYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray2bin_tracker_if #(.WIDTH(WIDTH), .POS_W(POS_W)) bus_if ();

  gray2bin_tracker #(.WIDTH(WIDTH), .POS_W(POS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {bit v; int g;} samp_t;
  samp_t pipe[$];
  bit    m_have;
  int    m_prev, m_pos, m_errs;
  int    exp_bin, exp_bv, exp_up, exp_dn, exp_err;

  function automatic int g2b(input int g);
    int b = 0;
    for (int k = 0; k < WIDTH; k++) b ^= (g >> k);
    return b % MOD;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  task automatic model_edge(input bit r, input bit c, input bit v, input int g);
    samp_t s;
    int    b, d;
    exp_bv = 0; exp_up = 0; exp_dn = 0; exp_err = 0;
    if (r || c) begin
      pipe.delete();
      for (int i = 0; i < LAT - 1; i++) pipe.push_back('{1'b0, 0});
      m_have = 0; m_prev = 0; m_pos = 0; m_errs = 0; exp_bin = 0;
    end else begin
      pipe.push_back('{v, g});
      s = pipe.pop_front();
      if (s.v) begin
        b = g2b(s.g);
        exp_bv = 1;
        if (m_have) begin
          d = (b - m_prev + MOD) % MOD;
          if (d == 1) begin
            exp_up = 1; m_pos = (m_pos + 1) % 65536;
          end else if (d == MOD - 1) begin
            exp_dn = 1; m_pos = (m_pos + 65535) % 65536;
          end else if (d != 0) begin
            exp_err = 1; if (m_errs < 255) m_errs++;
          end
        end
        m_have = 1; m_prev = b; exp_bin = b;
      end
    end
  endtask

  // One clock cycle: drive, clock, advance model, compare.
  task automatic cyc(input bit r, input bit c, input bit v, input int g);
    rst              = r;
    bus_if.clr       = c;
    bus_if.gin_valid = v;
    bus_if.gin       = g[WIDTH-1:0];
    @(posedge clk);
    model_edge(r, c, v, g);
    #1;
    check_val("bin_out",   bus_if.bin_out,   exp_bin);
    check_val("bin_valid", bus_if.bin_valid, exp_bv);
    check_val("step_up",   bus_if.step_up,   exp_up);
    check_val("step_dn",   bus_if.step_dn,   exp_dn);
    check_val("step_err",  bus_if.step_err,  exp_err);
    check_val("position",  bus_if.position,  m_pos);
    check_val("err_cnt",   bus_if.err_cnt,   m_errs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  int found;
  int drv_bin;

  initial begin
    rst = 1'b1; bus_if.clr = 1'b0; bus_if.gin_valid = 1'b0; bus_if.gin = '0;

    // Reset held two cycles with a valid sample present.
    cyc(1, 0, 1, 5);
    cyc(1, 0, 1, 5);
    idle(LAT + 1);

    // Count up 0..4, then through 5,6,7 and wrap to 0.
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 3);
    cyc(0, 0, 1, 2); cyc(0, 0, 1, 6);
    idle(LAT);
    check_val("cnt_up_pos", bus_if.position, 4);
    cyc(0, 0, 1, 7); cyc(0, 0, 1, 5); cyc(0, 0, 1, 4); cyc(0, 0, 1, 0);
    idle(LAT);
    check_val("wrap_up_pos", bus_if.position, 8);

    // Wrap downwards from a cleared state.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 4);
    idle(LAT);
    check_val("wrap_dn_pos", bus_if.position, 16'hFFFF);

    // Illegal jumps and saturation.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 3);
    idle(LAT);
    check_val("err_one", bus_if.err_cnt, 1);
    check_val("err_pos", bus_if.position, 0);
    for (int i = 0; i < 256; i++) cyc(0, 0, 1, (i % 2 == 0) ? 0 : 3);
    idle(LAT);
    check_val("err_sat", bus_if.err_cnt, 255);

    // clr colliding with a valid sample at position 5.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 3);
    cyc(0, 0, 1, 2); cyc(0, 0, 1, 6); cyc(0, 0, 1, 7);
    idle(LAT);
    check_val("clr_pre_pos", bus_if.position, 5);
    cyc(0, 1, 1, 2);
    check_val("clr_pos", bus_if.position, 0);
    cyc(0, 0, 1, 5);
    idle(LAT);
    check_val("clr_init_bin", bus_if.bin_out, 6);
    check_val("clr_init_pos", bus_if.position, 0);

    // Latency of a single isolated sample.
    cyc(0, 1, 0, 0);
    found = 0;
    cyc(0, 0, 1, 1);
    if (bus_if.bin_valid) found = 1;
    for (int i = 2; i <= 8; i++) begin
      cyc(0, 0, 0, 0);
      if (bus_if.bin_valid && found == 0) found = i;
    end
    check_val("latency", found, LAT);

    // Randomized traffic, biased toward legal single steps.
    drv_bin = 0;
    for (int i = 0; i < 2000; i++) begin
      bit r, c, v;
      int g;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0, 1, 2:    drv_bin = (drv_bin + 1) % MOD;
        3, 4, 5:    drv_bin = (drv_bin + MOD - 1) % MOD;
        6:          drv_bin = drv_bin;
        default:    drv_bin = $urandom_range(0, MOD - 1);
      endcase
      g = b2g(drv_bin);
      cyc(r, c, v, g);
    end
    idle(LAT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gray2bin_tracker.md
GRAY2BIN_TRACKER -- requirements
Module: gray2bin_tracker

Interface
REQ-001 Parameter WIDTH, default 3: Gray input and binary output width; SHALL be >= 2.
REQ-002 Parameter POS_W, default 16: width of the position accumulator.
REQ-003 Port clk  input  1: sole clock; all state SHALL update on the rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port clr  input  1: synchronous soft clear of tracking state.
REQ-006 Port gin  input  WIDTH: Gray-coded sample.
REQ-007 Port gin_valid  input  1: gin is qualified this cycle.
REQ-008 Port bin_out  output  WIDTH: registered binary equivalent of the last accepted sample.
REQ-009 Port bin_valid  output  1: one-cycle pulse when bin_out updates.
REQ-010 Port step_up  output  1: one-cycle pulse for a +1 step.
REQ-011 Port step_dn  output  1: one-cycle pulse for a -1 step.
REQ-012 Port step_err  output  1: one-cycle pulse for an illegal jump.
REQ-013 Port position  output  POS_W: signed up/down step accumulator, two's complement.
REQ-014 Port err_cnt  output  8: saturating count of illegal jumps.

Function
REQ-015 Conversion SHALL be b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1]^g[i], for i from WIDTH-2 down to 0.
REQ-016 Latency SHALL be one cycle: gin_valid sampled at edge N gives bin_valid, bin_out and the step pulses valid after edge N+1, all asserted in the same cycle.
REQ-017 The FSM SHALL have two states, INIT and TRACK; reset and clr SHALL both select INIT.
REQ-018 INIT with gin_valid: load bin_out and prev, pulse bin_valid, issue no step pulse, leave position unchanged, go to TRACK.
REQ-019 TRACK with gin_valid: compute d = (new - prev) mod 2^WIDTH, pulse bin_valid, then set prev to new in every case.
REQ-020 d == 0: no step pulse; position unchanged.
REQ-021 d == 1: pulse step_up; position increments by 1.
REQ-022 d == 2^WIDTH-1: pulse step_dn; position decrements by 1.
REQ-023 Any other d: pulse step_err; position unchanged; err_cnt increments, saturating at 255.
REQ-024 Wrap-around across binary 2^WIDTH-1 and 0 SHALL be treated as a legal +1 or -1 step.
REQ-025 position SHALL wrap modulo 2^POS_W with no saturation and no flag.
REQ-026 Without gin_valid, all pulses SHALL be 0 and all state SHALL hold.
REQ-027 clr asserted SHALL:
- return the FSM to INIT;
- zero position, err_cnt, the pulses and bin_out;
- discard a gin_valid sample in the same cycle (clr wins).
REQ-028 At most one of step_up, step_dn and step_err SHALL be high in any cycle.

Reset
REQ-029 rst high at a clock edge SHALL force:
- FSM to INIT;
- bin_out, prev, position and err_cnt to 0;
- bin_valid, step_up, step_dn and step_err to 0.
REQ-030 rst SHALL take priority over clr and gin_valid.
REQ-031 rst asserted mid-stream SHALL drop any in-flight sample, including samples in the synchroniser stages.
REQ-032 The first sample after rst deasserts SHALL be handled as an INIT sample.

Configuration
REQ-033 Macro G2B_INSYNC_EN defined: gin and gin_valid SHALL each pass through a two-flop synchroniser before the conversion stage, giving latency 3 cycles; synchroniser flops SHALL clear on rst and clr.
REQ-034 Macro G2B_INSYNC_EN undefined: no synchroniser; latency SHALL be 1 cycle as in REQ-016.

Verification
REQ-035 Reset: assert rst for 2 cycles with gin_valid=1 and gin=3'b101 -> all outputs 0 during and after; the next sample produces no step pulse.
REQ-036 Count up (WIDTH=3): valid Gray 000, 001, 011, 010, 110 -> bin_out 0, 1, 2, 3, 4, each one cycle later; step_up x4; position=4.
REQ-037 Wrap in both directions: from bin 7 (Gray 100) apply Gray 000 -> step_up. Then from a cleared state apply Gray 000 then 100 -> step_dn and position=16'hFFFF.
REQ-038 Illegal jump: Gray 000 then 011 (bin 2) -> step_err, err_cnt=1, position unchanged. 256 further illegal jumps -> err_cnt holds at 255.
REQ-039 clr collision: clr=1 and gin_valid=1 in the same cycle while position=5 -> position=0, no bin_valid; the next sample is handled as an INIT sample.
REQ-040 Synchroniser build: with G2B_INSYNC_EN defined, a single valid sample -> bin_valid exactly 3 cycles later. With the macro undefined -> exactly 1 cycle later.
